// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one line-wide memory port between the I-cache
// refill side (read only) and the D-cache side (line read / write-back).
// One transaction in flight at a time. The arbiter asserts a strobe toward
// memory, waits for mem_done, then pulses the owner's ack for one cycle.
// Optional feature: define ARB_ROUND_ROBIN_EN to use round-robin arbitration
// on an I/D collision. Without it, D always wins.
//
// Handshake: a requester holds req (with its address/data) until it sees its
// one-cycle ack. The arbiter holds mem_read or mem_write (with mem_addr and
// mem_wdata) until it samples mem_done. mem_done outside MEM is ignored.
module mem_line_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_ack,
  output logic [WORD_SIZE*LINE_WORDS-1:0] i_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
  output logic                            d_ack,
  output logic [WORD_SIZE*LINE_WORDS-1:0] d_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_done,
  output logic                            busy,
  output logic [CNT_W-1:0]                i_grant_cnt,
  output logic [CNT_W-1:0]                d_grant_cnt,
  output logic [1:0]                      dbg_state
);

  localparam int LW = WORD_SIZE * LINE_WORDS;
  // Clears the word-within-line offset bits of an address.
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~(WORD_SIZE'(LINE_WORDS - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   owner_q;   // 0 = I side, 1 = D side
  logic                   we_q;      // only ever set for a D write
  logic [WORD_SIZE-1:0]   addr_q;
  logic [LW-1:0]          wdata_q;
  logic [LW-1:0]          i_rdata_q, d_rdata_q;
  logic [CNT_W-1:0]       i_cnt_q, d_cnt_q;
  logic                   grant_v;   // a grant happens at the coming edge
  logic                   grant_d;   // that grant goes to D
  logic                   collide_d; // winner on a simultaneous request

`ifdef ARB_ROUND_ROBIN_EN
  logic                   last_grant_q; // 0 = I granted last, 1 = D

  // Remember who was granted most recently, including lone requests.
  always_ff @(posedge clk) begin
    if (reset)        last_grant_q <= 1'b0;
    else if (grant_v) last_grant_q <= grant_d;
  end

  assign collide_d = ~last_grant_q;
`else
  assign collide_d = 1'b1;
`endif

  // Arbitration: only requests seen in IDLE are considered.
  always_comb begin
    grant_v = 1'b0;
    grant_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (i_req && d_req) begin
        grant_v = 1'b1;
        grant_d = collide_d;
      end else if (d_req) begin
        grant_v = 1'b1;
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_v = 1'b1;
        grant_d = 1'b0;
      end
    end
  end

  // Next-state logic for IDLE -> MEM -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_v) state_d = S_MEM;
      S_MEM:   if (mem_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latch the winning request so memory sees stable address/data in MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_v) begin
      owner_q <= grant_d;
      we_q    <= grant_d & d_we;
      addr_q  <= (grant_d ? d_addr : i_addr) & ALIGN_MASK;
      wdata_q <= d_wdata;
    end
  end

  // Capture read data for the owner on the single completing MEM cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (state_q == S_MEM && mem_done && !we_q) begin
      if (owner_q) d_rdata_q <= mem_rdata;
      else         i_rdata_q <= mem_rdata;
    end
  end

  // Saturating grant counters: stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else if (grant_v) begin
      if (grant_d && d_cnt_q != '1)  d_cnt_q <= d_cnt_q + CNT_W'(1);
      if (!grant_d && i_cnt_q != '1) i_cnt_q <= i_cnt_q + CNT_W'(1);
    end
  end

  assign mem_read    = (state_q == S_MEM) && !we_q;
  assign mem_write   = (state_q == S_MEM) && we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_ack       = (state_q == S_RESP) && !owner_q;
  assign d_ack       = (state_q == S_RESP) && owner_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: randomized request rounds against a
// transaction-level reference (arbitration order, line memory, counters).
// A second instance with 2-bit counters shares all inputs so that saturation
// can be reached quickly.
module tb_mem_line_arbiter;

  typedef logic [63:0] line_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0;
  line_t       d_wdata = '0;
  line_t       mem_rdata;
  logic        mem_done;
  logic        i_ack, d_ack, mem_read, mem_write, busy;
  line_t       i_rdata, d_rdata, mem_wdata;
  logic [15:0] mem_addr, i_grant_cnt, d_grant_cnt;
  logic [1:0]  dbg_state;

  logic        s_i_ack, s_d_ack, s_mem_read, s_mem_write, s_busy;
  line_t       s_i_rdata, s_d_rdata, s_mem_wdata;
  logic [15:0] s_mem_addr;
  logic [1:0]  s_i_cnt, s_d_cnt, s_dbg_state;

  mem_line_arbiter dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .dbg_state(dbg_state)
  );

  mem_line_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(s_i_ack),
    .i_rdata(s_i_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(s_d_ack), .d_rdata(s_d_rdata),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(s_busy), .i_grant_cnt(s_i_cnt), .d_grant_cnt(s_d_cnt),
    .dbg_state(s_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [80:0] exp_mem_q[$];  // {is_write, aligned addr, wdata}
  logic [64:0] exp_ack_q[$];  // {side (1 = D), expected rdata}
  line_t env_mem[int];        // what the memory model actually holds
  line_t ref_mem[int];        // what the reference says memory should hold
  int    m_icnt, m_dcnt;
  bit    m_last;              // 1 = D granted last
  line_t m_irdata, m_drdata;
  bit    rr_mode;

  // memory-model controls (written by the driver only)
  int mem_lat = 0, mem_hold = 1, pulse_cnt = 0;
  bit mem_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic line_t init_line(input int a);
    logic [15:0] w;
    w = a[15:0];
    return {w, ~w, w ^ 16'h5a5a, w + 16'd1};
  endfunction

  function automatic line_t env_read(input int a);
    return env_mem.exists(a) ? env_mem[a] : init_line(a);
  endfunction

  function automatic line_t ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [63:0] sat(input int v, input int max);
    return 64'((v > max) ? max : v);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_grant(input bit side_d, input bit dwe, input logic [15:0] ia,
                             input logic [15:0] da, input line_t dw);
    logic [15:0] a;
    line_t data;
    m_last = side_d;
    if (side_d) begin
      m_dcnt++;
      a = da & 16'hfffc;
      if (dwe) begin
        ref_mem[int'(a)] = dw;
        exp_mem_q.push_back({1'b1, a, dw});
        exp_ack_q.push_back({1'b1, m_drdata});
      end else begin
        data = ref_read(int'(a));
        m_drdata = data;
        exp_mem_q.push_back({1'b0, a, 64'd0});
        exp_ack_q.push_back({1'b1, data});
      end
    end else begin
      m_icnt++;
      a = ia & 16'hfffc;
      data = ref_read(int'(a));
      m_irdata = data;
      exp_mem_q.push_back({1'b0, a, 64'd0});
      exp_ack_q.push_back({1'b0, data});
    end
  endtask

  task automatic model_round(input bit use_i, input bit use_d, input bit dwe,
                             input logic [15:0] ia, input logic [15:0] da, input line_t dw);
    bit first_d;
    if (use_i && use_d) first_d = rr_mode ? !m_last : 1'b1;
    else                first_d = use_d;
    model_grant(first_d, dwe, ia, da, dw);
    if (use_i && use_d) model_grant(!first_d, dwe, ia, da, dw);
  endtask

  task automatic model_reset();
    m_icnt = 0; m_dcnt = 0; m_last = 1'b0;
    m_irdata = '0; m_drdata = '0;
    exp_mem_q.delete();
    exp_ack_q.delete();
  endtask

  // ---------------- memory model ----------------
  task automatic mem_start_check();
    logic [80:0] it;
    if (exp_mem_q.size() == 0) begin
      check("mem_unexpected", 64'd1, 64'd0);
    end else begin
      it = exp_mem_q.pop_front();
      check("mem_strobe", {62'd0, mem_write, mem_read}, it[80] ? 64'd2 : 64'd1);
      check("mem_addr", 64'(mem_addr), 64'(it[79:64]));
      if (it[80]) check("mem_wdata", mem_wdata, it[63:0]);
    end
  endtask

  initial begin
    int wait_left, hold_left, pulse_seen;
    bit active;
    mem_done = 1'b0; mem_rdata = '0;
    wait_left = 0; hold_left = 0; pulse_seen = 0; active = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0; wait_left = 0; hold_left = 0; mem_done = 1'b0;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) mem_done = 1'b0;
      end else if (pulse_seen != pulse_cnt) begin
        pulse_seen = pulse_cnt;
        mem_done = 1'b1;
        hold_left = 1;
      end else if ((mem_read || mem_write) && !mem_stall) begin
        if (!active) begin
          active = 1'b1;
          wait_left = mem_lat;
          mem_start_check();
        end
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          if (mem_write) env_mem[int'(mem_addr)] = mem_wdata;
          else           mem_rdata = env_read(int'(mem_addr));
          mem_done = 1'b1;
          hold_left = mem_hold;
          active = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_counters();
    check("i_grant_cnt", 64'(i_grant_cnt), sat(m_icnt, 65535));
    check("d_grant_cnt", 64'(d_grant_cnt), sat(m_dcnt, 65535));
    check("i_grant_cnt_sat", 64'(s_i_cnt), sat(m_icnt, 3));
    check("d_grant_cnt_sat", 64'(s_d_cnt), sat(m_dcnt, 3));
  endtask

  task automatic run_round(input bit use_i, input bit use_d, input bit dwe,
                           input logic [15:0] ia, input logic [15:0] da, input line_t dw,
                           input int lat, input int hold);
    int iter;
    bit pend_i, pend_d, single;
    logic [64:0] it;
    model_round(use_i, use_d, dwe, ia, da, dw);
    @(negedge clk);
    mem_lat = lat; mem_hold = hold;
    i_req = use_i; i_addr = ia;
    d_req = use_d; d_we = dwe; d_addr = da; d_wdata = dw;
    pend_i = use_i; pend_d = use_d; single = use_i ^ use_d;
    iter = 0;
    while ((pend_i || pend_d) && iter < 200) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        check("ack_onehot", 64'(i_ack & d_ack), 64'd0);
        if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", 64'd1, 64'd0);
        end else begin
          it = exp_ack_q.pop_front();
          check("ack_side", 64'(d_ack), 64'(it[64]));
          check("rdata", d_ack ? d_rdata : i_rdata, it[63:0]);
          if (single) check("ack_latency", 64'(iter), 64'(lat + 1));
        end
        if (i_ack) begin i_req = 1'b0; pend_i = 1'b0; end
        if (d_ack) begin d_req = 1'b0; pend_d = 1'b0; end
      end
      iter++;
    end
    if (pend_i || pend_d) begin
      check("ack_timeout", 64'd1, 64'd0);
      i_req = 1'b0; d_req = 1'b0;
    end
    @(negedge clk);
    check("no_extra_ack", {62'd0, i_ack, d_ack}, 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check_counters();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int kind;
`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    // Values while reset is held.
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check("rst_acks", {62'd0, i_ack, d_ack}, 64'd0);
    check("rst_i_rdata", i_rdata, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check_counters();
    reset = 1'b0;

    // Directed I read from 0x0013, done on the 2nd MEM cycle.
    env_mem[16] = 64'h1111_2222_3333_4444;
    ref_mem[16] = 64'h1111_2222_3333_4444;
    run_round(1'b1, 1'b0, 1'b0, 16'h0013, 16'h0, 64'h0, 1, 1);
    // D write-back, then D read of the same line.
    run_round(1'b0, 1'b1, 1'b1, 16'h0, 16'h0042, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1);
    run_round(1'b0, 1'b1, 1'b0, 16'h0, 16'h0041, 64'h0, 2, 1);
    // Collision (D read + I read) right after a fresh reset.
    apply_reset();
    run_round(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0030, 64'h0, 1, 1);
    run_round(1'b1, 1'b1, 1'b0, 16'h0024, 16'h0013, 64'h0, 0, 2);
    // mem_done stretched over three cycles.
    run_round(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0, 64'h0, 0, 3);

    // A stray mem_done pulse while idle.
    @(negedge clk);
    pulse_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_pulse_ack", {62'd0, i_ack, d_ack}, 64'd0);
      check("idle_pulse_state", 64'(dbg_state), 64'd0);
    end

    // Reset while a read waits for memory forever.
    @(negedge clk);
    mem_stall = 1'b1;
    i_req = 1'b1; i_addr = 16'h0101;
    repeat (3) @(negedge clk);
    check("stall_mem_read", 64'(mem_read), 64'd1);
    check("stall_busy", 64'(busy), 64'd1);
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    check("midrst_mem_read", 64'(mem_read), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ack", {62'd0, i_ack, d_ack}, 64'd0);
    reset = 1'b0; mem_stall = 1'b0;
    model_reset();
    check_counters();
    run_round(1'b1, 1'b0, 1'b0, 16'h0101, 16'h0, 64'h0, 1, 1);

    // Randomized rounds.
    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 3);
      run_round(kind != 1, kind != 0, 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
                {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("exp_mem_drained", 64'(exp_mem_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares one line-wide backing memory port between the instruction-cache refill side (I, read-only) and the data-cache side (D, line read or line write-back).
- Sits between the two caches and the memory model; the cpu top keeps separate I/D request interfaces, and the memory sees a single requester.
- Non-pipelined: one outstanding memory transaction at a time. Fixed-priority arbitration by default.
- Keeps saturating per-port grant counters for performance reporting.

Parameters:
- WORD_SIZE, 16, bits per word.
- LINE_WORDS, 4, words per cache line; line width LW = WORD_SIZE*LINE_WORDS.
- CNT_W, 16, width of grant counters.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  I-side line read request; held with i_addr until i_ack.
- i_addr  in  WORD_SIZE  I-side word address.
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  LW  returned line for the I side.
- d_req  in  1  D-side request; held with d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = line write, 0 = line read.
- d_addr  in  WORD_SIZE  D-side word address.
- d_wdata  in  LW  write line.
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (for a read); write complete.
- d_rdata  out  LW  returned line for the D side.
- mem_read  out  1  memory line read strobe, held until mem_done.
- mem_write  out  1  memory line write strobe, held until mem_done.
- mem_addr  out  WORD_SIZE  line-aligned address (low log2(LINE_WORDS) bits forced to 0).
- mem_wdata  out  LW  write line.
- mem_rdata  in  LW  read line; valid when mem_done.
- mem_done  in  1  memory completion (read data valid or write accepted).
- busy  out  1  high in any state other than IDLE.
- i_grant_cnt  out  CNT_W  number of I grants, saturating.
- d_grant_cnt  out  CNT_W  number of D grants, saturating.

Behaviour:
- States: IDLE, MEM, RESP.
- Reset values: state = IDLE. All strobes, acks, busy, counters, rdata and last_grant = 0.
- IDLE:
  - Arbitrate sampled requests: both high -> winner per policy; one high -> that side.
  - On a grant: register owner, line-aligned addr, we and wdata; assert mem_read (I, or D with d_we=0) or mem_write (D with d_we=1) from the next cycle; go to MEM; increment the owner's counter (saturates at all-ones, never wraps).
  - No request: stay in IDLE.
- MEM:
  - Strobe and mem_addr/mem_wdata held stable.
  - On mem_done: capture mem_rdata into the owner's rdata register (reads only; writes leave d_rdata unchanged), drop the strobe at that edge, go to RESP.
  - A multi-cycle mem_done counts once.
- RESP:
  - Owner's ack = 1 for exactly this cycle; next state IDLE.
  - The requester drops req at the same edge, so IDLE never re-grants a completed request.
- Latency: grant edge -> strobe visible 1 cycle later. Ack asserted the cycle after mem_done. Minimum request-to-ack is 3 cycles when mem_done arrives on the first MEM cycle.
- mem_done in IDLE or RESP is ignored.
- i_rdata and d_rdata hold their last value between acks.
- Requests arriving while busy wait; they are sampled only in IDLE.
- Fixed priority (default): D beats I. I can starve while D requests back-to-back; accepted.
- Reset mid-operation: any state -> IDLE at the next edge. Strobes drop, no ack is issued, counters clear, and the in-flight transaction is abandoned.
- mem_read and mem_write are never high together. Acks are never high together.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register (reset 0 = I).
  - On a simultaneous I/D request in IDLE, grant the side not granted last.
  - last_grant updates on every grant, single-requester grants included.
- Undefined: fixed D-over-I priority; no last_grant register exists.

Test Plan:
- I-only read: i_req, i_addr=0x0013, memory returns 0x1111_2222_3333_4444 with mem_done on the 2nd MEM cycle -> mem_addr=0x0010, mem_read only; i_ack one cycle, 4 cycles after grant; i_rdata = that line; i_grant_cnt=1.
- D write-back: d_req, d_we=1, d_addr=0x0042, d_wdata=0xAAAA_BBBB_CCCC_DDDD -> mem_write with mem_addr=0x0040 and that data; d_ack one cycle; d_rdata unchanged; mem_read stays 0.
- Simultaneous i_req and d_req (d_we=0), held across two transactions:
  - Default build: D served first, then I; counters 1/1.
  - ARB_ROUND_ROBIN_EN build after reset: D first (last_grant=I), then I.
  - ARB_ROUND_ROBIN_EN build, repeated collisions: grants alternate.
- Stretched and idle mem_done: mem_done held high for 3 cycles -> exactly one ack; a mem_done pulse in IDLE -> no ack, state stays IDLE.
- Reset during MEM (mem_done never given) -> next edge: mem_read=0, busy=0, counters 0; no ack; a new i_req is then served normally.
- Saturation: CNT_W=2, 5 I transactions -> i_grant_cnt stays at 3.
